// File: rtl/dmem_responder_if.sv
// -----------------------------------------------------------------------------
// dmem_responder_if
// Load/store bus between the MEM stage (master) and a data-memory responder
// (slave).
//
// Handshake: a request transfers on a rising clock edge where req_valid and
// req_ready are both 1. The master holds req_valid and the request fields
// stable until that edge. The fields may change freely after it. req_valid
// is never queued, so a request presented while req_ready=0 is simply not
// taken. resp_valid is a one-cycle strobe that qualifies resp_rdata and
// resp_err. It has no back-pressure.
//
// Signals:
//   req_valid  master -> slave  request present
//   req_ready  slave  -> master request can be taken this cycle
//   req_we     master -> slave  1 = store, 0 = load
//   req_addr   master -> slave  byte address (doubleword aligned)
//   req_wdata  master -> slave  store data
//   resp_valid slave  -> master one-cycle response strobe
//   resp_rdata slave  -> master load data
//   resp_err   slave  -> master misaligned / out-of-range request
// -----------------------------------------------------------------------------
interface dmem_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [63:0] req_addr;
   logic [63:0] req_wdata;
   logic        resp_valid;
   logic [63:0] resp_rdata;
   logic        resp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Data-memory target for the MEM stage. It accepts one doubleword load or
// store, waits LATENCY cycles, and then emits a one-cycle response. Stores
// commit on the cycle that leaves the response state, so a later load
// always sees them.
//
// Parameters:
//   DEPTH    number of 64-bit doublewords (power of two, >= 2)
//   LATENCY  cycles from acceptance to response (0..15)
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous reset, active high
//   bus   dmem_responder_if.slave (request/response channel)
//   busy  a transaction is in progress (FSM not in IDLE)
// -----------------------------------------------------------------------------
module dmem_responder #(
   parameter int DEPTH   = 256,
   parameter int LATENCY = 2
) (
   input  logic              clk,
   input  logic              rst,
   dmem_responder_if.slave   bus,
   output logic              busy
);

   localparam int         IDX_W     = $clog2(DEPTH);
   localparam logic [3:0] WAIT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t      state;
   logic [3:0]  cnt;
   logic        we_q;
   logic [63:0] addr_q;
   logic [63:0] wdata_q;

   logic [63:0] mem [DEPTH];

   // Operation evaluated on the RESP entry edge. With LATENCY=0 that edge is
   // the acceptance edge itself, so the live bus fields are used because the
   // capture registers are not loaded yet.
   logic             entry_we;
   logic [63:0]      entry_addr;
   logic [IDX_W-1:0] entry_idx;
   logic             entry_err;

   always_comb begin
      entry_we   = we_q;
      entry_addr = addr_q;
      if (state == IDLE) begin
         entry_we   = bus.req_we;
         entry_addr = bus.req_addr;
      end
      entry_idx = entry_addr[IDX_W+2:3];
      // Out of range means any doubleword-index bit above the storage index is set.
      entry_err = (entry_addr[2:0] != 3'd0) || (entry_addr[63:IDX_W+3] != '0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         cnt            <= 4'd0;
         we_q           <= 1'b0;
         addr_q         <= '0;
         wdata_q        <= '0;
         bus.resp_valid <= 1'b0;
         bus.resp_rdata <= '0;
         bus.resp_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  we_q    <= bus.req_we;
                  addr_q  <= bus.req_addr;
                  wdata_q <= bus.req_wdata;
                  if (LATENCY > 0) begin
                     state <= WAIT;
                     cnt   <= WAIT_INIT;
                  end else begin
                     state          <= RESP;
                     bus.resp_valid <= 1'b1;
                     bus.resp_err   <= entry_err;
                     bus.resp_rdata <= (!entry_we && !entry_err) ? mem[entry_idx] : '0;
                  end
               end
            end
            WAIT: begin
               if (cnt == 4'd0) begin
                  state          <= RESP;
                  bus.resp_valid <= 1'b1;
                  bus.resp_err   <= entry_err;
                  bus.resp_rdata <= (!entry_we && !entry_err) ? mem[entry_idx] : '0;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            RESP: begin
               state          <= IDLE;
               bus.resp_valid <= 1'b0;
               bus.resp_err   <= 1'b0;
               bus.resp_rdata <= '0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // The store commits on the RESP exit edge. resp_err still holds this
   // transaction's error flag there. An async reset forces the state to IDLE,
   // so an aborted store can never reach this write.
   always_ff @(posedge clk) begin
      if (state == RESP && we_q && !bus.resp_err) begin
         mem[addr_q[IDX_W+2:3]] <= wdata_q;
      end
   end

   assign bus.req_ready = (state == IDLE) && !rst;
   assign busy          = (state != IDLE);

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
// Bench for dmem_responder. dut_a uses LATENCY=2 and dut_b uses LATENCY=0.
// The reference storage model is a plain array. Its error rule is written
// arithmetically: misaligned, or the doubleword index is >= DEPTH.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

   localparam int DEPTH = 256;
   localparam int LAT_A = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic busy_a, busy_b;

   int total = 0;
   int bad   = 0;

   logic [63:0] model_a [DEPTH];
   logic [63:0] model_b [DEPTH];
   logic [63:0] exp_q [$];

   dmem_responder_if a_if ();
   dmem_responder_if b_if ();

   dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT_A)) dut_a (
      .clk (clk), .rst (rst), .bus (a_if.slave), .busy (busy_a)
   );

   dmem_responder #(.DEPTH(DEPTH), .LATENCY(0)) dut_b (
      .clk (clk), .rst (rst), .bus (b_if.slave), .busy (busy_b)
   );

   always #5 clk = ~clk;

   // ---------------- reference helpers ----------------
   function automatic logic addr_bad(input logic [63:0] a);
      return (a % 8 != 0) || ((a / 8) >= 64'(DEPTH));
   endfunction

   function automatic logic [63:0] rand_data();
      return {$urandom(), $urandom()};
   endfunction

   // Mostly aligned in-range addresses below max_idx, plus some misaligned and some out of range.
   function automatic logic [63:0] rand_addr(input int max_idx);
      int sel;
      logic [63:0] a;
      sel = $urandom_range(0, 9);
      if (sel == 0)      a = 64'($urandom_range(0, max_idx - 1)) * 8 + 64'($urandom_range(1, 7));
      else if (sel == 1) a = 64'(DEPTH) * 8 + 64'($urandom_range(0, 1000)) * 8;
      else if (sel == 2) a = {1'b1, 63'($urandom_range(0, max_idx - 1)) * 8};
      else               a = 64'($urandom_range(0, max_idx - 1)) * 8;
      return a;
   endfunction

   // ---------------- driver ----------------
   // Runs one transaction on dut_a. It reports the response cycle offset from
   // acceptance, the number of response strobes in cycles T0..T0+LAT_A+1, the
   // cycles with req_ready high in T0..T0+LAT_A, and req_ready in T0+LAT_A+1.
   task automatic drive_a(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                          output int lat, output int strobes, output int ready_hi,
                          output logic ready_after, output logic [63:0] rdata, output logic err);
      int guard;
      guard = 0;
      @(negedge clk);
      while (a_if.req_ready !== 1'b1 && guard < 50) begin @(negedge clk); guard++; end
      if (guard >= 50) begin
         total++; bad++;
         $display("FAIL drive_a_ready_timeout: req_ready never rose within 50 cycles");
      end
      a_if.req_valid = 1'b1; a_if.req_we = we; a_if.req_addr = addr; a_if.req_wdata = wdata;
      @(posedge clk); #1;
      a_if.req_valid = 1'b0; a_if.req_we = ~we; a_if.req_addr = rand_data(); a_if.req_wdata = rand_data();
      lat = -1; strobes = 0; ready_hi = 0; ready_after = 1'b0; rdata = '0; err = 1'b0;
      for (int n = 0; n <= LAT_A + 1; n++) begin
         if (a_if.resp_valid === 1'b1) begin
            strobes++;
            if (lat < 0) begin lat = n; rdata = a_if.resp_rdata; err = a_if.resp_err; end
         end
         if (n <= LAT_A) begin
            if (a_if.req_ready !== 1'b0) ready_hi++;
            @(posedge clk); #1;
         end else begin
            ready_after = a_if.req_ready;
         end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      a_if.req_valid = 1'b0; a_if.req_we = 1'b0; a_if.req_addr = '0; a_if.req_wdata = '0;
      b_if.req_valid = 1'b0; b_if.req_we = 1'b0; b_if.req_addr = '0; b_if.req_wdata = '0;
      repeat (3) @(posedge clk);
      #1;
      total++; if (a_if.resp_valid !== 1'b0) begin bad++; $display("FAIL rst_resp_valid: got %b want 0", a_if.resp_valid); end
      total++; if (a_if.resp_rdata !== 64'h0) begin bad++; $display("FAIL rst_resp_rdata: got %h want 0", a_if.resp_rdata); end
      total++; if (a_if.resp_err !== 1'b0) begin bad++; $display("FAIL rst_resp_err: got %b want 0", a_if.resp_err); end
      total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy_a); end
      total++; if (a_if.req_ready !== 1'b0) begin bad++; $display("FAIL rst_ready_in_reset: got %b want 0", a_if.req_ready); end
      @(negedge clk);
      rst = 1'b0;
      #1;
      total++; if (a_if.req_ready !== 1'b1) begin bad++; $display("FAIL rst_ready_after: got %b want 1", a_if.req_ready); end
      total++; if (b_if.req_ready !== 1'b1) begin bad++; $display("FAIL rst_ready_after_b: got %b want 1", b_if.req_ready); end
   endtask

   task automatic test_fill();
      int lat, st, rh; logic ra; logic [63:0] rd; logic er; logic [63:0] d;
      for (int i = 0; i < DEPTH; i++) begin
         d = rand_data();
         drive_a(1'b1, 64'(i) * 8, d, lat, st, rh, ra, rd, er);
         model_a[i] = d;
         total++; if (lat !== LAT_A || er !== 1'b0 || rd !== 64'h0) begin
            bad++; $display("FAIL fill_store[%0d]: lat=%0d err=%b rdata=%h want lat=%0d err=0 rdata=0", i, lat, er, rd, LAT_A);
         end
      end
   endtask

   task automatic test_store_basic();
      int lat, st, rh; logic ra; logic [63:0] rd; logic er;
      drive_a(1'b1, 64'h10, 64'hDEADBEEFCAFEF00D, lat, st, rh, ra, rd, er);
      model_a[2] = 64'hDEADBEEFCAFEF00D;
      total++; if (lat !== LAT_A) begin bad++; $display("FAIL store1_latency: got %0d want %0d", lat, LAT_A); end
      total++; if (st !== 1) begin bad++; $display("FAIL store1_strobes: got %0d want 1", st); end
      total++; if (rh !== 0) begin bad++; $display("FAIL store1_ready_low: got %0d high cycles want 0", rh); end
      total++; if (ra !== 1'b1) begin bad++; $display("FAIL store1_ready_after: got %b want 1", ra); end
      total++; if (er !== 1'b0) begin bad++; $display("FAIL store1_err: got %b want 0", er); end
      total++; if (rd !== 64'h0) begin bad++; $display("FAIL store1_rdata: got %h want 0", rd); end
   endtask

   task automatic test_load_basic();
      int lat, st, rh; logic ra; logic [63:0] rd; logic er;
      drive_a(1'b0, 64'h10, 64'h0, lat, st, rh, ra, rd, er);
      total++; if (lat !== LAT_A) begin bad++; $display("FAIL load1_latency: got %0d want %0d", lat, LAT_A); end
      total++; if (rd !== 64'hDEADBEEFCAFEF00D) begin bad++; $display("FAIL load1_rdata: got %h want deadbeefcafef00d", rd); end
      total++; if (er !== 1'b0) begin bad++; $display("FAIL load1_err: got %b want 0", er); end
   endtask

   task automatic test_misaligned();
      int lat, st, rh; logic ra; logic [63:0] rd; logic er;
      drive_a(1'b1, 64'h13, 64'h1, lat, st, rh, ra, rd, er);
      total++; if (er !== 1'b1) begin bad++; $display("FAIL misal_store_err: got %b want 1", er); end
      total++; if (rd !== 64'h0) begin bad++; $display("FAIL misal_store_rdata: got %h want 0", rd); end
      drive_a(1'b0, 64'h10, 64'h0, lat, st, rh, ra, rd, er);
      total++; if (rd !== 64'hDEADBEEFCAFEF00D) begin bad++; $display("FAIL misal_reload: got %h want deadbeefcafef00d", rd); end
      total++; if (er !== 1'b0) begin bad++; $display("FAIL misal_reload_err: got %b want 0", er); end
   endtask

   // Out-of-range load with req_valid held. The second request (load 0x10) is
   // already on the bus and must only be taken once req_ready returns.
   task automatic test_hold();
      int resp_at[$];
      int guard;
      guard = 0;
      @(negedge clk);
      while (a_if.req_ready !== 1'b1 && guard < 50) begin @(negedge clk); guard++; end
      a_if.req_valid = 1'b1; a_if.req_we = 1'b0; a_if.req_addr = 64'(DEPTH) * 8; a_if.req_wdata = '0;
      @(posedge clk); #1;
      a_if.req_addr = 64'h10;
      for (int n = 0; n <= 6; n++) begin
         if (a_if.resp_valid === 1'b1) resp_at.push_back(n);
         if (n == 1) begin
            total++; if (busy_a !== 1'b1) begin bad++; $display("FAIL hold_busy: got %b want 1", busy_a); end
         end
         if (n == 2) begin
            total++; if (a_if.resp_err !== 1'b1) begin bad++; $display("FAIL oor_err: got %b want 1", a_if.resp_err); end
            total++; if (a_if.resp_rdata !== 64'h0) begin bad++; $display("FAIL oor_rdata: got %h want 0", a_if.resp_rdata); end
         end
         if (n == 3) begin
            total++; if (a_if.req_ready !== 1'b1) begin bad++; $display("FAIL hold_ready_t3: got %b want 1", a_if.req_ready); end
         end
         if (n == 4) begin
            total++; if (a_if.req_ready !== 1'b0) begin bad++; $display("FAIL hold_ready_t4: got %b want 0", a_if.req_ready); end
            a_if.req_valid = 1'b0;
         end
         if (n == 6) begin
            total++; if (a_if.resp_err !== 1'b0) begin bad++; $display("FAIL hold_second_err: got %b want 0", a_if.resp_err); end
            total++; if (a_if.resp_rdata !== model_a[2]) begin bad++; $display("FAIL hold_second_rdata: got %h want %h", a_if.resp_rdata, model_a[2]); end
         end
         @(posedge clk); #1;
      end
      total++;
      if (resp_at.size() != 2) begin
         bad++; $display("FAIL hold_resp_count: got %0d want 2", resp_at.size());
      end else if (resp_at[0] != 2 || resp_at[1] != 6) begin
         bad++; $display("FAIL hold_resp_cycles: got %0d,%0d want 2,6", resp_at[0], resp_at[1]);
      end
   endtask

   task automatic test_reset_abort();
      int lat, st, rh; logic ra; logic [63:0] rd; logic er;
      int guard;
      guard = 0;
      @(negedge clk);
      while (a_if.req_ready !== 1'b1 && guard < 50) begin @(negedge clk); guard++; end
      a_if.req_valid = 1'b1; a_if.req_we = 1'b1; a_if.req_addr = 64'h20; a_if.req_wdata = 64'h55;
      @(posedge clk); #1;
      a_if.req_valid = 1'b0;
      repeat (LAT_A) begin @(posedge clk); #1; end
      total++; if (a_if.resp_valid !== 1'b1) begin bad++; $display("FAIL abort_resp_before: got %b want 1", a_if.resp_valid); end
      #2 rst = 1'b1;
      #1;
      total++; if (a_if.resp_valid !== 1'b0) begin bad++; $display("FAIL abort_resp_drop: got %b want 0", a_if.resp_valid); end
      total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b want 0", busy_a); end
      total++; if (a_if.req_ready !== 1'b0) begin bad++; $display("FAIL abort_ready_in_reset: got %b want 0", a_if.req_ready); end
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      total++; if (a_if.req_ready !== 1'b1) begin bad++; $display("FAIL abort_ready_after: got %b want 1", a_if.req_ready); end
      drive_a(1'b0, 64'h20, 64'h0, lat, st, rh, ra, rd, er);
      total++; if (rd !== model_a[4]) begin bad++; $display("FAIL abort_reload: got %h want %h", rd, model_a[4]); end
      total++; if (st !== 1) begin bad++; $display("FAIL abort_reload_strobes: got %0d want 1", st); end
   endtask

   task automatic test_random();
      int lat, st, rh; logic ra; logic [63:0] rd; logic er;
      logic we; logic [63:0] a, d, exp_d; logic exp_e;
      for (int k = 0; k < 40; k++) begin
         we = 1'($urandom_range(0, 1));
         a  = rand_addr(DEPTH);
         d  = rand_data();
         exp_e = addr_bad(a);
         exp_d = (!we && !exp_e) ? model_a[a / 8] : 64'h0;
         drive_a(we, a, d, lat, st, rh, ra, rd, er);
         if (we && !exp_e) model_a[a / 8] = d;
         total++; if (lat !== LAT_A || st !== 1 || rh !== 0 || ra !== 1'b1) begin
            bad++; $display("FAIL rand_timing[%0d]: lat=%0d strobes=%0d ready_hi=%0d ready_after=%b want %0d/1/0/1", k, lat, st, rh, ra, LAT_A);
         end
         total++; if (er !== exp_e) begin bad++; $display("FAIL rand_err[%0d] addr=%h: got %b want %b", k, a, er, exp_e); end
         total++; if (rd !== exp_d) begin bad++; $display("FAIL rand_rdata[%0d] addr=%h: got %h want %h", k, a, rd, exp_d); end
      end
   endtask

   // LATENCY=0: req_valid stays high and each accepted request responds in the
   // following cycle. The next request is accepted two edges after the previous one.
   task automatic test_back_to_back();
      logic we; logic [63:0] a, d; logic exp_e; logic [63:0] exp_d;
      int guard;
      guard = 0;
      @(negedge clk);
      while (b_if.req_ready !== 1'b1 && guard < 50) begin @(negedge clk); guard++; end
      for (int k = 0; k < 40; k++) begin
         if (k < 16) begin we = 1'b1; a = 64'(k) * 8; end
         else begin we = 1'($urandom_range(0, 1)); a = rand_addr(16); end
         d = rand_data();
         exp_e = addr_bad(a);
         exp_q.push_back((!we && !exp_e) ? model_b[a / 8] : 64'h0);
         b_if.req_valid = 1'b1; b_if.req_we = we; b_if.req_addr = a; b_if.req_wdata = d;
         @(posedge clk); #1;
         exp_d = exp_q.pop_front();
         total++; if (b_if.resp_valid !== 1'b1 || b_if.req_ready !== 1'b0 || busy_b !== 1'b1) begin
            bad++; $display("FAIL b2b_resp_cycle[%0d]: resp_valid=%b req_ready=%b busy=%b want 1/0/1", k, b_if.resp_valid, b_if.req_ready, busy_b);
         end
         total++; if (b_if.resp_err !== exp_e) begin bad++; $display("FAIL b2b_err[%0d] addr=%h: got %b want %b", k, a, b_if.resp_err, exp_e); end
         total++; if (b_if.resp_rdata !== exp_d) begin bad++; $display("FAIL b2b_rdata[%0d] addr=%h: got %h want %h", k, a, b_if.resp_rdata, exp_d); end
         if (we && !exp_e) model_b[a / 8] = d;
         // Scramble the fields during the response cycle; they must not matter now.
         b_if.req_we = 1'($urandom_range(0, 1)); b_if.req_addr = rand_data(); b_if.req_wdata = rand_data();
         if (k == 39) b_if.req_valid = 1'b0;
         @(posedge clk); #1;
         total++; if (b_if.resp_valid !== 1'b0 || b_if.req_ready !== 1'b1) begin
            bad++; $display("FAIL b2b_gap_cycle[%0d]: resp_valid=%b req_ready=%b want 0/1", k, b_if.resp_valid, b_if.req_ready);
         end
         // Restore a valid request before the next acceptance edge.
         @(negedge clk);
      end
      b_if.req_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_fill();
      test_store_basic();
      test_load_basic();
      test_misaligned();
      test_hold();
      test_reset_abort();
      test_random();
      test_back_to_back();
      repeat (2) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder (target side) for the MEM-stage load/store interface; replaces the single-cycle data memory when variable access latency is needed.
- Accepts one doubleword read or write request per transaction over a valid/ready handshake, waits a programmable number of cycles, then returns a one-cycle response with read data or an error flag.
- The MEM stage holds the pipeline while req_ready is low or a response is outstanding.

Parameters:
DEPTH, 256, number of 64-bit doublewords in storage (power of two)
LATENCY, 2, wait cycles between request acceptance and response (0..15)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-high
req_valid  input  1  initiator presents a request
req_ready  output  1  responder can accept a request this cycle
req_we  input  1  1 = store, 0 = load
req_addr  input  64  byte address; must be doubleword aligned
req_wdata  input  64  store data
resp_valid  output  1  one-cycle response strobe
resp_rdata  output  64  load data, valid with resp_valid
resp_err  output  1  request was misaligned or out of range, valid with resp_valid
busy  output  1  transaction in progress (state != IDLE)

Behaviour:
- Reset (async, rst=1): state=IDLE, wait counter=0, resp_valid=0, resp_rdata=0, resp_err=0, busy=0. req_ready=1 once rst deasserts. Storage array is not cleared.
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On an edge with req_valid=1, the request is accepted (edge T0). req_we, req_addr and req_wdata are captured; the initiator may change these inputs afterwards.
  - Go to WAIT with counter=LATENCY-1 if LATENCY>0; otherwise go directly to RESP.
- WAIT:
  - req_ready=0.
  - Counter decrements each edge. The edge where counter==0 moves to RESP.
- RESP entry edge:
  - Index = captured addr[63:3].
  - err = (addr[2:0]!=0) OR (index >= DEPTH).
  - For a load with no error: resp_rdata <= mem[index].
  - For a store, or any error: resp_rdata <= 0.
  - resp_err <= err.
- RESP:
  - resp_valid=1 for exactly one cycle (edge T0+LATENCY through edge T0+LATENCY+1). req_ready=0.
  - On the exit edge: a store with no error commits mem[index] <= wdata. State returns to IDLE; resp_valid, resp_err and resp_rdata return to 0.
- Timing:
  - Response appears LATENCY cycles after acceptance.
  - Earliest next acceptance is edge T0+LATENCY+2 (req_ready high in the cycle after RESP).
- req_valid during WAIT or RESP is ignored. It is not queued; the initiator must hold it until accepted.
- Errored stores never modify storage. Errored loads return 0.
- Load after store to the same address in a later transaction returns the stored data, since the commit precedes the next acceptance.
- Reset asserted mid-transaction (WAIT or RESP) aborts the transaction immediately. No commit occurs, resp_valid drops asynchronously, and no response is ever issued for the aborted request.
- Index uses only bits [log2(DEPTH)+2:3] for storage access, after the range check on the full address.
- busy = (state != IDLE); req_ready = (state == IDLE) AND NOT rst.

Test Plan:
1. Reset, then store addr=0x10 wdata=0xDEADBEEFCAFEF00D with LATENCY=2 -> accepted at T0, resp_valid high only in cycle T0+2 with resp_err=0 and resp_rdata=0, req_ready low for cycles T0..T0+2 and high at T0+3.
2. Load addr=0x10 after scenario 1 -> resp_valid at T0+2, resp_rdata=0xDEADBEEFCAFEF00D, resp_err=0.
3. Store addr=0x13 (misaligned) wdata=0x1, then load addr=0x10 -> first response has resp_err=1; second response returns 0xDEADBEEFCAFEF00D (storage unchanged).
4. Load addr=DEPTH*8 (0x800) -> resp_err=1, resp_rdata=0; req_valid held high during WAIT is not accepted until req_ready=1.
5. Store addr=0x20 wdata=0x55, assert rst during the RESP cycle, release, then load 0x20 -> resp_valid drops immediately, state IDLE; load returns the prior contents (not 0x55).
6. Rebuild with LATENCY=0: back-to-back loads with req_valid held high -> accepts every 2 cycles, resp_valid in the cycle after each acceptance.
